write_mem_backend: RTL

//  Storage stage directly downstream of the AXI write slave. Takes each write beat the slave

---
 rtl/axi_wr_pkg.sv | 18 +
 rtl/write_mem_backend_if.sv | 13 +
 rtl/write_mem_backend_fifo.sv | 51 +++++
 rtl/write_mem_backend.sv | 112 +++++++++++
 4 files changed

// File: rtl/axi_wr_pkg.sv
// rtl/axi_wr_pkg.sv - shared types and defaults for the write memory backend
package axi_wr_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_COMMIT = 2'd2
    } commit_state_t;

    // Word-index width for a memory of the given depth (at least one bit).
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/write_mem_backend_if.sv
// rtl/write_mem_backend_if.sv - write beat handshake between AXI write slave and backend
interface write_mem_backend_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              writeavail;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              finishwrite;

    modport master (output writeavail, wr_data, wr_addr, input finishwrite);
    modport slave  (input writeavail, wr_data, wr_addr, output finishwrite);
endinterface

// File: rtl/write_mem_backend_fifo.sv
// rtl/write_mem_backend_fifo.sv - synchronous beat FIFO holding {addr,data} entries
module wr_beat_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] entries [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign full      = (level == LW'(DEPTH));
    assign empty     = (level == '0);
    assign head_data = entries[rd_ptr];

    // Pointers wrap naturally; the level counter tells full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) entries[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/write_mem_backend.sv
// rtl/write_mem_backend.sv - accepts write beats, buffers them, commits to memory after WR_LAT
module write_mem_backend
    import axi_wr_pkg::*;
#(
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                MEM_WORDS  = 256,
    parameter int                FIFO_DEPTH = 4,
    parameter int                WR_LAT     = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    write_mem_backend_if.slave            wr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          mem_busy,
    output logic                          err_oob,
    input  logic [idx_w(MEM_WORDS)-1:0]   rd_addr,
    output logic [DATA_W-1:0]             rd_data
);
    localparam int IW = idx_w(MEM_WORDS);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = $clog2(WR_LAT) + 1;
    localparam logic [CW-1:0]  LAT_M1 = CW'(WR_LAT - 1);
    localparam commit_state_t  ARM_ST = (WR_LAT == 1) ? ST_COMMIT : ST_WAIT;

    commit_state_t      state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic               capture;
    logic               pop;
    logic               full, empty;
    logic [ADDR_W+DATA_W-1:0] head;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_data;
    logic [ADDR_W-1:0]  word;
    logic               in_range;
    logic               more;
    logic [DATA_W-1:0]  mem [MEM_WORDS];

    // The finishwrite cycle never captures, so a held writeavail counts once per pulse.
    assign capture = wr.writeavail && !full && !wr.finishwrite;

    wr_beat_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .push      (capture),
        .push_data ({wr.wr_addr, wr.wr_data}),
        .pop       (pop),
        .head_data (head),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    assign {head_addr, head_data} = head;
    // Unsigned subtraction: a base above the address means out of range.
    assign word     = (head_addr - BASE_ADDR) >> 2;
    assign in_range = (head_addr >= BASE_ADDR) && ((word >> IW) == '0);
    assign more     = (fifo_level > LW'(1)) || capture;
    assign mem_busy = (fifo_level != '0) || (state != ST_IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pop     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    state_n = ARM_ST;
                    cnt_n   = LAT_M1;
                end
            end
            ST_WAIT: begin
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) state_n = ST_COMMIT;
            end
            ST_COMMIT: begin
                pop = 1'b1;
                if (more) begin
                    state_n = ARM_ST;
                    cnt_n   = LAT_M1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            wr.finishwrite <= 1'b0;
            err_oob        <= 1'b0;
            rd_data        <= '0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            wr.finishwrite <= capture;
            err_oob        <= (state == ST_COMMIT) && !in_range;
            rd_data        <= mem[rd_addr];
        end
    end

    always_ff @(posedge ACLK) begin
        if ((state == ST_COMMIT) && in_range) mem[word[IW-1:0]] <= head_data;
    end
endmodule
